// File: rtl/regfile_write_arbiter.sv
// Sole owner of the register file write port: clears every entry after reset or on
// request, otherwise grants one round-robin valid/ready requester per cycle.
module regfile_write_arbiter #(
  parameter int NREQ  = 2,
  parameter int AW    = 6,
  parameter int DW    = 64,
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_start,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [AW-1:0]     rf_addressw,
  output logic [DW-1:0]     rf_writeData,
  output logic              rf_writeEn,
  output logic              busy,
  output logic              dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {CLEAR = 1'b0, ARB = 1'b1} state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant;
  logic [PW-1:0] grant_next;
  logic          any_valid;
  logic          hs;

  // Handshake: a write transfers on a clk edge where req_valid[i] & req_ready[i].
  // Ready is a function of state, clear_start and req_valid only, never addr/data.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_valid && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        grant     = PW'((int'(rr_ptr) + k) % NREQ);
        any_valid = 1'b1;
      end
    end
  end

  // A clear request in ARB pre-empts every requester in the same cycle.
  assign req_ready  = (state == ARB && !clear_start && any_valid) ? (NREQ'(1) << grant) : '0;
  assign hs         = |req_ready;
  assign grant_next = (grant == PW'(NREQ - 1)) ? '0 : grant + PW'(1);
  assign busy       = (state == CLEAR);
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CLEAR;
      clr_cnt      <= '0;
      rr_ptr       <= '0;
      rf_writeEn   <= 1'b0;
      rf_addressw  <= '0;
      rf_writeData <= '0;
    end else begin
      case (state)
        CLEAR: begin
          rf_writeEn   <= 1'b1;
          rf_addressw  <= clr_cnt;
          rf_writeData <= '0;
          if (clr_cnt == AW'(DEPTH - 1)) begin
            clr_cnt <= '0;
            state   <= ARB;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        ARB: begin
          if (clear_start) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            rf_writeEn <= 1'b0;
          end else if (hs) begin
            rf_addressw  <= req_addr[int'(grant)*AW +: AW];
            rf_writeData <= req_data[int'(grant)*DW +: DW];
            // Register x0 is hardwired zero: accept the request but drop the write.
            rf_writeEn   <= (req_addr[int'(grant)*AW +: AW] != '0);
            rr_ptr       <= grant_next;
          end else begin
            rf_writeEn <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Random and directed stimulus for regfile_write_arbiter, checked against a queue-based
// reference model of the write stream and a behavioural regfile fed by the write port.
module tb_regfile_write_arbiter;
  localparam int NREQ  = 2;
  localparam int AW    = 6;
  localparam int DW    = 64;
  localparam int DEPTH = 64;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clear_start;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      rf_addressw;
  logic [DW-1:0]      rf_writeData;
  logic               rf_writeEn;
  logic               busy;
  logic               dbg_state;

  regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rf_addressw(rf_addressw), .rf_writeData(rf_writeData),
    .rf_writeEn(rf_writeEn), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural register file driven by the DUT's write port
  logic [DW-1:0] rf [DEPTH];
  always @(posedge clk) if (rf_writeEn === 1'b1) rf[rf_addressw] <= rf_writeData;

  // Reference model state
  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    m_mem [DEPTH];
  int               m_ptr;
  int               m_clear_left;
  logic             p_valid [NREQ];
  logic [AW-1:0]    p_addr  [NREQ];
  logic [DW-1:0]    p_data  [NREQ];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write the DUT presents must be the next expected one
  logic [AW+DW-1:0] mon_e;
  always @(negedge clk) begin
    if (rf_writeEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL write_unexpected: got addr %0h data %0h expected none at %0t",
                 rf_addressw, rf_writeData, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write", {58'd0, rf_addressw, rf_writeData}, {58'd0, mon_e});
        m_mem[mon_e[AW+DW-1:DW]] = mon_e[DW-1:0];
      end
    end
  end

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_valid[i] = 1'b1;
    p_addr[i]  = a;
    p_data[i]  = d;
  endtask

  // One clock cycle: present inputs, predict ready/busy and the write issued on this edge
  task automatic step(input logic cs);
    logic [NREQ-1:0] er;
    logic            eb;
    int              g;
    bit              hit;
    @(negedge clk);
    clear_start = cs;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = p_valid[i];
      req_addr[i*AW +: AW] = p_addr[i];
      req_data[i*DW +: DW] = p_data[i];
    end
    #1;
    er = '0;
    g  = 0;
    hit = 0;
    if (m_clear_left > 0) begin
      eb = 1'b1;
      exp_q.push_back({AW'(DEPTH - m_clear_left), {DW{1'b0}}});
      m_clear_left--;
    end else begin
      eb = 1'b0;
      if (cs) begin
        m_clear_left = DEPTH;
      end else begin
        for (int k = 0; k < NREQ; k++)
          if (!hit && p_valid[(m_ptr + k) % NREQ]) begin
            hit = 1;
            g   = (m_ptr + k) % NREQ;
          end
        if (hit) begin
          er[g] = 1'b1;
          if (p_addr[g] != '0) exp_q.push_back({p_addr[g], p_data[g]});
          m_ptr      = (g + 1) % NREQ;
          p_valid[g] = 1'b0;
        end
      end
    end
    chk("busy", {127'd0, busy}, {127'd0, eb});
    chk("req_ready", {126'd0, req_ready}, {126'd0, er});
    @(posedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  {127'd0, busy},       128'd1);
    chk({tag, "_wen"},   {127'd0, rf_writeEn}, 128'd0);
    chk({tag, "_addr"},  {122'd0, rf_addressw}, 128'd0);
    chk({tag, "_data"},  {64'd0, rf_writeData}, 128'd0);
    chk({tag, "_ready"}, {126'd0, req_ready},  128'd0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n        = 1'b1;
    m_clear_left = DEPTH;
  endtask

  initial begin
    rst_n       = 1'b0;
    clear_start = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    m_ptr        = 0;
    m_clear_left = 0;
    for (int i = 0; i < NREQ; i++) begin
      p_valid[i] = 1'b0;
      p_addr[i]  = '0;
      p_data[i]  = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      rf[i]    = {$urandom, $urandom} | 64'h1;
      m_mem[i] = '0;
    end
    #1;
    chk_reset_outputs("reset");
    release_reset();

    // Clear sequence after reset, with a requester waiting (must see no ready)
    set_req(1, 6'd7, {$urandom, $urandom});
    repeat (DEPTH) step(1'b0);
    step(1'b0);

    // Single writer
    set_req(0, 6'd1, 64'h1234567890ABCDEF);
    step(1'b0);

    // Write to x0 is accepted but dropped
    set_req(1, 6'd0, 64'hFEDCBA0987654321);
    step(1'b0);

    // Both requesters valid continuously
    for (int c = 0; c < 8; c++) begin
      if (!p_valid[0]) set_req(0, 6'd2, {$urandom, $urandom});
      if (!p_valid[1]) set_req(1, 6'd3, {$urandom, $urandom});
      step(1'b0);
    end
    p_valid[1] = 1'b0;
    step(1'b0);

    // Clear request beats a waiting requester
    set_req(0, 6'd9, {$urandom, $urandom});
    step(1'b1);
    repeat (DEPTH) step(1'b0);
    step(1'b0);

    // Asynchronous reset in the middle of a clear
    step(1'b1);
    repeat (20) step(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    exp_q.delete();
    m_ptr        = 0;
    m_clear_left = 0;
    release_reset();
    repeat (DEPTH) step(1'b0);

    // Randomized traffic with occasional clear requests
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!p_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, AW'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom});
      step($urandom_range(0, 49) == 0);
    end

    for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b0;
    repeat (DEPTH + 4) step(1'b0);

    chk("queue_drained", 128'(exp_q.size()), 128'd0);
    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("regfile[%0d]", i), {64'd0, rf[i]}, {64'd0, m_mem[i]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
